// File: rtl/ipsxe_floating_point_pkg.sv
// Shared definitions for the floating-point IP library: op-codes of the
// sign unit and a helper locating the sign bit of a packed operand.
package ipsxe_floating_point_pkg;

    localparam logic [1:0] OP_ABS      = 2'b00;
    localparam logic [1:0] OP_NEG      = 2'b01;
    localparam logic [1:0] OP_COPYSIGN = 2'b10;
    localparam logic [1:0] OP_PASS     = 2'b11;

    // Sign bit sits at the MSB of {sign, exponent, fraction}.
    function automatic int sign_idx(input int width);
        return width - 1;
    endfunction

endpackage

// File: rtl/ipsxe_floating_point_sign_v1_0_if.sv
// Stream bundle of the sign unit: operand A, operand B, op and result
// channels. Optional result tuser under IPSXE_FLOATING_POINT_SIGN_NAN_FLAG_EN.
interface ipsxe_floating_point_sign_v1_0_if
    import ipsxe_floating_point_pkg::*;
#(
    parameter int EXP_WIDTH  = 8,
    parameter int FRAC_WIDTH = 23
);
    localparam int WIDTH = 1 + EXP_WIDTH + FRAC_WIDTH;

    logic [WIDTH-1:0] i_axi4s_a_tdata;
    logic             i_axi4s_a_tvalid;
    logic             o_axi4s_a_tready;
    logic [WIDTH-1:0] i_axi4s_b_tdata;
    logic             i_axi4s_b_tvalid;
    logic             o_axi4s_b_tready;
    logic [1:0]       i_axi4s_op_tdata;
    logic             i_axi4s_op_tvalid;
    logic             o_axi4s_op_tready;
    logic [WIDTH-1:0] o_axi4s_result_tdata;
    logic             o_axi4s_result_tvalid;
    logic             i_axi4s_result_tready;
`ifdef IPSXE_FLOATING_POINT_SIGN_NAN_FLAG_EN
    logic [1:0]       o_axi4s_result_tuser;
`endif

    // Seen from the sign unit.
    modport slave (
        input  i_axi4s_a_tdata, i_axi4s_a_tvalid,
        input  i_axi4s_b_tdata, i_axi4s_b_tvalid,
        input  i_axi4s_op_tdata, i_axi4s_op_tvalid,
        input  i_axi4s_result_tready,
        output o_axi4s_a_tready, o_axi4s_b_tready, o_axi4s_op_tready,
        output o_axi4s_result_tdata, o_axi4s_result_tvalid
`ifdef IPSXE_FLOATING_POINT_SIGN_NAN_FLAG_EN
        , output o_axi4s_result_tuser
`endif
    );

    // Seen from the surrounding datapath driving the unit.
    modport master (
        output i_axi4s_a_tdata, i_axi4s_a_tvalid,
        output i_axi4s_b_tdata, i_axi4s_b_tvalid,
        output i_axi4s_op_tdata, i_axi4s_op_tvalid,
        output i_axi4s_result_tready,
        input  o_axi4s_a_tready, o_axi4s_b_tready, o_axi4s_op_tready,
        input  o_axi4s_result_tdata, o_axi4s_result_tvalid
`ifdef IPSXE_FLOATING_POINT_SIGN_NAN_FLAG_EN
        , input o_axi4s_result_tuser
`endif
    );

endinterface

// File: rtl/ipsxe_floating_point_skid_v1_0.sv
// Main + skid output register pair. The upstream sees ready whenever the
// skid slot is free, so it never combinationally depends on downstream
// ready. Beats leave strictly in acceptance order.
module ipsxe_floating_point_skid_v1_0
    import ipsxe_floating_point_pkg::*;
#(
    parameter int PW = 32
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_valid,
    output logic          o_ready,
    input  logic [PW-1:0] i_data,
    output logic          o_valid,
    input  logic          i_ready,
    output logic [PW-1:0] o_data
);

    logic          r_main_vld;
    logic          r_skid_vld;
    logic [PW-1:0] r_main_data;
    logic [PW-1:0] r_skid_data;

    logic          w_drain;
    logic          w_load;
    logic          w_main_open;

    assign o_ready     = ~r_skid_vld & ~i_rst;
    assign w_drain     = r_main_vld & i_ready;
    assign w_load      = i_valid & o_ready;
    // Main can take a beat when empty or emptying this cycle.
    assign w_main_open = ~r_main_vld | w_drain;

    assign o_valid = r_main_vld;
    assign o_data  = r_main_data;

    // Skid has priority into main (it is older); a new beat only goes to
    // skid when main is occupied and not draining.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_main_vld  <= 1'b0;
            r_skid_vld  <= 1'b0;
            r_main_data <= '0;
            r_skid_data <= '0;
        end else begin
            if (w_main_open) begin
                if (r_skid_vld) begin
                    r_main_data <= r_skid_data;
                    r_main_vld  <= 1'b1;
                end else if (w_load) begin
                    r_main_data <= i_data;
                    r_main_vld  <= 1'b1;
                end else begin
                    r_main_vld  <= 1'b0;
                end
            end
            if (r_skid_vld && w_drain) begin
                r_skid_vld <= 1'b0;
            end else if (w_load && !w_main_open) begin
                r_skid_data <= i_data;
                r_skid_vld  <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/ipsxe_floating_point_sign_v1_0.sv
// Registered sign-manipulation unit: abs / negate / copy-sign / pass on
// A, joined with B and op streams, output through a main+skid pair.
// Optional {is_nan, is_zero} result tuser: IPSXE_FLOATING_POINT_SIGN_NAN_FLAG_EN.
module ipsxe_floating_point_sign_v1_0
    import ipsxe_floating_point_pkg::*;
#(
    parameter  int EXP_WIDTH  = 8,
    parameter  int FRAC_WIDTH = 23,
    localparam int WIDTH      = 1 + EXP_WIDTH + FRAC_WIDTH
) (
    input logic                          i_aclk,
    input logic                          i_areset,
    ipsxe_floating_point_sign_v1_0_if.slave s_axis
);

    localparam int SIGN = sign_idx(WIDTH);
`ifdef IPSXE_FLOATING_POINT_SIGN_NAN_FLAG_EN
    localparam int PW = WIDTH + 2;
`else
    localparam int PW = WIDTH;
`endif

    logic             w_ready;
    logic             w_fire;
    logic             w_sign;
    logic [WIDTH-1:0] w_result;
    logic [PW-1:0]    w_payload;
    logic [PW-1:0]    w_out;
    logic             w_out_vld;
    logic             w_unused_b;

    // Only B's sign participates; the rest is folded away deliberately.
    assign w_unused_b = ^s_axis.i_axi4s_b_tdata[SIGN-1:0];

    assign s_axis.o_axi4s_a_tready  = w_ready;
    assign s_axis.o_axi4s_b_tready  = w_ready;
    assign s_axis.o_axi4s_op_tready = w_ready;

    assign w_fire = s_axis.i_axi4s_a_tvalid & s_axis.i_axi4s_b_tvalid &
                    s_axis.i_axi4s_op_tvalid & w_ready;

    // Sign selection; exponent and fraction always pass through untouched,
    // NaN/Inf included.
    always_comb begin
        w_sign = s_axis.i_axi4s_a_tdata[SIGN];
        case (s_axis.i_axi4s_op_tdata)
            OP_ABS:      w_sign = 1'b0;
            OP_NEG:      w_sign = ~s_axis.i_axi4s_a_tdata[SIGN];
            OP_COPYSIGN: w_sign = s_axis.i_axi4s_b_tdata[SIGN];
            default:     w_sign = s_axis.i_axi4s_a_tdata[SIGN];
        endcase
    end

    assign w_result = {w_sign, s_axis.i_axi4s_a_tdata[SIGN-1:0]};

`ifdef IPSXE_FLOATING_POINT_SIGN_NAN_FLAG_EN
    logic [EXP_WIDTH-1:0]  w_exp;
    logic [FRAC_WIDTH-1:0] w_frac;
    logic                  w_is_nan;
    logic                  w_is_zero;

    // Flags derive from A's fields, which the result shares.
    assign w_exp     = s_axis.i_axi4s_a_tdata[SIGN-1 -: EXP_WIDTH];
    assign w_frac    = s_axis.i_axi4s_a_tdata[FRAC_WIDTH-1:0];
    assign w_is_nan  = (&w_exp) & (|w_frac);
    assign w_is_zero = ~(|w_exp) & ~(|w_frac);
    assign w_payload = {w_is_nan, w_is_zero, w_result};

    assign s_axis.o_axi4s_result_tuser = w_out[WIDTH+1:WIDTH];
`else
    assign w_payload = w_result;
`endif

    assign s_axis.o_axi4s_result_tdata  = w_out[WIDTH-1:0];
    assign s_axis.o_axi4s_result_tvalid = w_out_vld;

    ipsxe_floating_point_skid_v1_0 #(
        .PW (PW)
    ) u_skid (
        .i_clk   (i_aclk),
        .i_rst   (i_areset),
        .i_valid (w_fire),
        .o_ready (w_ready),
        .i_data  (w_payload),
        .o_valid (w_out_vld),
        .i_ready (s_axis.i_axi4s_result_tready),
        .o_data  (w_out)
    );

endmodule

// File: tb/tb_ipsxe_floating_point_sign_v1_0.sv
// Bench for the sign unit: directed cases, back-pressure, staggered join,
// randomized traffic against a behavioural model, reset mid-stream.
module tb_ipsxe_floating_point_sign_v1_0;

    localparam int EW = 8;
    localparam int FW = 23;
    localparam int W  = 1 + EW + FW;

    logic clk = 1'b0;
    logic rst = 1'b1;

    ipsxe_floating_point_sign_v1_0_if #(.EXP_WIDTH(EW), .FRAC_WIDTH(FW)) ifc ();

    ipsxe_floating_point_sign_v1_0 #(.EXP_WIDTH(EW), .FRAC_WIDTH(FW)) dut (
        .i_aclk   (clk),
        .i_areset (rst),
        .s_axis   (ifc)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [W+1:0] exp_q[$];

    // Reference: {flags, result} from the arithmetic meaning of each op.
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [1:0] op);
        logic [W-1:0] smask, mag, r, e, fr;
        logic [1:0]   f;
        smask = {1'b1, {(W-1){1'b0}}};
        mag   = a & ~smask;
        case (op)
            2'd0:    r = mag;
            2'd1:    r = a ^ smask;
            2'd2:    r = mag | (b & smask);
            default: r = a;
        endcase
        e  = mag >> FW;
        fr = mag - (e << FW);
        f  = 2'b00;
`ifdef IPSXE_FLOATING_POINT_SIGN_NAN_FLAG_EN
        f = {(e == (2**EW - 1)) && (fr != 0), (e == 0) && (fr == 0)};
`endif
        return {f, r};
    endfunction

    function automatic logic [W+1:0] obs();
`ifdef IPSXE_FLOATING_POINT_SIGN_NAN_FLAG_EN
        return {ifc.o_axi4s_result_tuser, ifc.o_axi4s_result_tdata};
`else
        return {2'b00, ifc.o_axi4s_result_tdata};
`endif
    endfunction

    task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [1:0] op);
        ifc.i_axi4s_a_tvalid  = v;
        ifc.i_axi4s_b_tvalid  = v;
        ifc.i_axi4s_op_tvalid = v;
        ifc.i_axi4s_a_tdata   = a;
        ifc.i_axi4s_b_tdata   = b;
        ifc.i_axi4s_op_tdata  = op;
    endtask

    function automatic logic rdy_all();
        return ifc.o_axi4s_a_tready & ifc.o_axi4s_b_tready & ifc.o_axi4s_op_tready;
    endfunction

    function automatic logic rdy_any();
        return ifc.o_axi4s_a_tready | ifc.o_axi4s_b_tready | ifc.o_axi4s_op_tready;
    endfunction

    task automatic test_reset();
        drive(1'b1, 32'h3F800000, 32'h0, 2'b11);
        ifc.i_axi4s_result_tready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (rdy_any() !== 1'b0) begin
            n_bad++; $display("FAIL reset_tready_in_reset got %b required 0", rdy_any());
        end
        n_cmp++;
        if (ifc.o_axi4s_result_tvalid !== 1'b0) begin
            n_bad++; $display("FAIL reset_tvalid got %b required 0", ifc.o_axi4s_result_tvalid);
        end
        drive(1'b0, '0, '0, 2'b00);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (rdy_all() !== 1'b1) begin
            n_bad++; $display("FAIL reset_tready_after got %b required 1", rdy_all());
        end
        n_cmp++;
        if (obs() !== '0 || ifc.o_axi4s_result_tvalid !== 1'b0) begin
            n_bad++; $display("FAIL reset_outputs got v=%b d=%h required v=0 d=0",
                              ifc.o_axi4s_result_tvalid, obs());
        end
    endtask

    task automatic test_directed();
        logic [W-1:0] ta[4], tb[4], te[4];
        logic [1:0]   to[4];
        ta = '{32'hC0490FDB, 32'h00000000, 32'h3F800000, 32'hBF800000};
        tb = '{32'h12345678, 32'h9ABCDEF0, 32'hBF000000, 32'h00000000};
        to = '{2'b00, 2'b01, 2'b10, 2'b11};
        te = '{32'h40490FDB, 32'h80000000, 32'hBF800000, 32'hBF800000};
        ifc.i_axi4s_result_tready = 1'b1;
        for (int i = 0; i <= 4; i++) begin
            @(posedge clk); #1;
            if (i < 4) drive(1'b1, ta[i], tb[i], to[i]);
            else       drive(1'b0, '0, '0, 2'b00);
            @(negedge clk);
            n_cmp++;
            if (i == 0) begin
                if (ifc.o_axi4s_result_tvalid !== 1'b0) begin
                    n_bad++; $display("FAIL directed_idle got v=%b required 0", ifc.o_axi4s_result_tvalid);
                end
            end else if (ifc.o_axi4s_result_tvalid !== 1'b1 || ifc.o_axi4s_result_tdata !== te[i-1]) begin
                n_bad++; $display("FAIL directed_%0d got v=%b d=%h required v=1 d=%h",
                                  i - 1, ifc.o_axi4s_result_tvalid, ifc.o_axi4s_result_tdata, te[i-1]);
            end
        end
        @(negedge clk);
        n_cmp++;
        if (ifc.o_axi4s_result_tvalid !== 1'b0) begin
            n_bad++; $display("FAIL directed_end got v=%b required 0", ifc.o_axi4s_result_tvalid);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] ba[3], bb[3];
        logic [1:0]   bo[3];
        logic [W+1:0] e;
        int idx = 0, outs = 0;
        for (int i = 0; i < 3; i++) begin
            ba[i] = $urandom; bb[i] = $urandom; bo[i] = 2'($urandom_range(3));
        end
        ifc.i_axi4s_result_tready = 1'b0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(posedge clk); #1;
            if (cyc == 6) ifc.i_axi4s_result_tready = 1'b1;
            if (idx < 3) drive(1'b1, ba[idx], bb[idx], bo[idx]);
            else         drive(1'b0, '0, '0, 2'b00);
            @(negedge clk);
            if (cyc == 4) begin
                n_cmp++;
                if (rdy_any() !== 1'b0 || idx != 2) begin
                    n_bad++; $display("FAIL b2b_full got rdy=%b accepted=%0d required rdy=0 accepted=2",
                                      rdy_any(), idx);
                end
                n_cmp++;
                if (ifc.o_axi4s_result_tvalid !== 1'b1 || obs() !== model(ba[0], bb[0], bo[0])) begin
                    n_bad++; $display("FAIL b2b_hold got v=%b d=%h required v=1 d=%h",
                                      ifc.o_axi4s_result_tvalid, obs(), model(ba[0], bb[0], bo[0]));
                end
            end
            if (ifc.o_axi4s_result_tvalid && ifc.i_axi4s_result_tready) begin
                n_cmp++;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
                if (obs() !== e) begin
                    n_bad++; $display("FAIL b2b_order got %h required %h", obs(), e);
                end
                outs++;
            end
            if (idx < 3 && rdy_all()) begin
                exp_q.push_back(model(ba[idx], bb[idx], bo[idx]));
                idx++;
            end
        end
        n_cmp++;
        if (outs != 3 || exp_q.size() != 0) begin
            n_bad++; $display("FAIL b2b_count got %0d beats required 3", outs);
        end
    endtask

    task automatic test_stagger();
        logic [W-1:0] a, b;
        a = $urandom; b = $urandom;
        ifc.i_axi4s_result_tready = 1'b1;
        for (int cyc = 0; cyc < 7; cyc++) begin
            @(posedge clk); #1;
            ifc.i_axi4s_a_tdata   = a;
            ifc.i_axi4s_b_tdata   = b;
            ifc.i_axi4s_op_tdata  = 2'b10;
            ifc.i_axi4s_a_tvalid  = (cyc <= 4);
            ifc.i_axi4s_b_tvalid  = (cyc >= 2 && cyc <= 4);
            ifc.i_axi4s_op_tvalid = (cyc == 4);
            @(negedge clk);
            n_cmp++;
            if (cyc == 5) begin
                if (ifc.o_axi4s_result_tvalid !== 1'b1 || obs() !== model(a, b, 2'b10)) begin
                    n_bad++; $display("FAIL stagger_fire got v=%b d=%h required v=1 d=%h",
                                      ifc.o_axi4s_result_tvalid, obs(), model(a, b, 2'b10));
                end
            end else if (ifc.o_axi4s_result_tvalid !== 1'b0) begin
                n_bad++; $display("FAIL stagger_cyc%0d got v=%b required 0", cyc, ifc.o_axi4s_result_tvalid);
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] a, b;
        logic [W+1:0] e, prev_d;
        logic prev_v = 1'b0, prev_r = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(posedge clk); #1;
            a = $urandom; b = $urandom;
            if ($urandom_range(3) == 0) a[W-2 -: EW] = '1;
            if ($urandom_range(3) == 0) a[W-2:0] = '0;
            drive(1'b0, a, b, 2'($urandom_range(3)));
            ifc.i_axi4s_a_tvalid      = ($urandom_range(3) != 0);
            ifc.i_axi4s_b_tvalid      = ($urandom_range(3) != 0);
            ifc.i_axi4s_op_tvalid     = ($urandom_range(3) != 0);
            ifc.i_axi4s_result_tready = ($urandom_range(2) != 0);
            @(negedge clk);
            if (prev_v && !prev_r) begin
                n_cmp++;
                if (ifc.o_axi4s_result_tvalid !== 1'b1 || obs() !== prev_d) begin
                    n_bad++; $display("FAIL rand_stable got v=%b d=%h required v=1 d=%h",
                                      ifc.o_axi4s_result_tvalid, obs(), prev_d);
                end
            end
            if (ifc.o_axi4s_result_tvalid && ifc.i_axi4s_result_tready) begin
                n_cmp++;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
                if (obs() !== e) begin
                    n_bad++; $display("FAIL rand_data got %h required %h", obs(), e);
                end
            end
            if (ifc.i_axi4s_a_tvalid && ifc.i_axi4s_b_tvalid && ifc.i_axi4s_op_tvalid && rdy_all())
                exp_q.push_back(model(ifc.i_axi4s_a_tdata, ifc.i_axi4s_b_tdata, ifc.i_axi4s_op_tdata));
            prev_v = ifc.o_axi4s_result_tvalid;
            prev_r = ifc.i_axi4s_result_tready;
            prev_d = obs();
        end
        @(posedge clk); #1;
        drive(1'b0, '0, '0, 2'b00);
        ifc.i_axi4s_result_tready = 1'b1;
        for (int cyc = 0; cyc < 4; cyc++) begin
            @(negedge clk);
            if (ifc.o_axi4s_result_tvalid) begin
                n_cmp++;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
                if (obs() !== e) begin
                    n_bad++; $display("FAIL rand_drain got %h required %h", obs(), e);
                end
            end
            @(posedge clk); #1;
        end
        n_cmp++;
        if (exp_q.size() != 0 || ifc.o_axi4s_result_tvalid !== 1'b0) begin
            n_bad++; $display("FAIL rand_lost got %0d pending required 0", exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset_midstream();
        logic [W-1:0] a;
        ifc.i_axi4s_result_tready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1 drive(1'b1, $urandom, $urandom, 2'($urandom_range(3)));
        end
        @(posedge clk); #1 drive(1'b0, '0, '0, 2'b00);
        @(negedge clk);
        n_cmp++;
        if (rdy_any() !== 1'b0 || ifc.o_axi4s_result_tvalid !== 1'b1) begin
            n_bad++; $display("FAIL rstmid_full got rdy=%b v=%b required rdy=0 v=1",
                              rdy_any(), ifc.o_axi4s_result_tvalid);
        end
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (ifc.o_axi4s_result_tvalid !== 1'b0 || obs() !== '0 || rdy_any() !== 1'b0) begin
            n_bad++; $display("FAIL rstmid_clear got v=%b d=%h rdy=%b required 0/0/0",
                              ifc.o_axi4s_result_tvalid, obs(), rdy_any());
        end
        #1 rst = 1'b0;
        ifc.i_axi4s_result_tready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (rdy_all() !== 1'b1 || ifc.o_axi4s_result_tvalid !== 1'b0) begin
            n_bad++; $display("FAIL rstmid_after got rdy=%b v=%b required rdy=1 v=0",
                              rdy_all(), ifc.o_axi4s_result_tvalid);
        end
        a = $urandom;
        @(posedge clk); #1 drive(1'b1, a, 32'h80000000, 2'b10);
        @(posedge clk); #1 drive(1'b0, '0, '0, 2'b00);
        @(negedge clk);
        n_cmp++;
        if (ifc.o_axi4s_result_tvalid !== 1'b1 || obs() !== model(a, 32'h80000000, 2'b10)) begin
            n_bad++; $display("FAIL rstmid_resume got v=%b d=%h required v=1 d=%h",
                              ifc.o_axi4s_result_tvalid, obs(), model(a, 32'h80000000, 2'b10));
        end
    endtask

`ifdef IPSXE_FLOATING_POINT_SIGN_NAN_FLAG_EN
    task automatic test_nan_flags();
        ifc.i_axi4s_result_tready = 1'b1;
        @(posedge clk); #1 drive(1'b1, 32'hFFC00000, 32'h0, 2'b00);
        @(posedge clk); #1 drive(1'b1, 32'h80000000, 32'h0, 2'b01);
        @(negedge clk);
        n_cmp++;
        if (ifc.o_axi4s_result_tdata !== 32'h7FC00000 || ifc.o_axi4s_result_tuser !== 2'b10) begin
            n_bad++; $display("FAIL nan_abs got d=%h u=%b required d=7fc00000 u=10",
                              ifc.o_axi4s_result_tdata, ifc.o_axi4s_result_tuser);
        end
        @(posedge clk); #1 drive(1'b0, '0, '0, 2'b00);
        @(negedge clk);
        n_cmp++;
        if (ifc.o_axi4s_result_tdata !== 32'h00000000 || ifc.o_axi4s_result_tuser !== 2'b01) begin
            n_bad++; $display("FAIL zero_neg got d=%h u=%b required d=00000000 u=01",
                              ifc.o_axi4s_result_tdata, ifc.o_axi4s_result_tuser);
        end
    endtask
`endif

    initial begin
        drive(1'b0, '0, '0, 2'b00);
        ifc.i_axi4s_result_tready = 1'b0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_stagger();
        test_random();
        test_reset_midstream();
`ifdef IPSXE_FLOATING_POINT_SIGN_NAN_FLAG_EN
        test_nan_flags();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
